// File: rtl/ahb_gpio_sequencer_if.sv
// AHB-Lite bus bundle between the GPIO sequencer (master) and the bus segment.
// The bus segment feeds the GPIO slave.
interface ahb_gpio_sequencer_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;

    modport master (output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                    input  HRDATA, HREADY);
    modport slave  (input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                    output HRDATA, HREADY);
endinterface

// File: rtl/ahb_gpio_sequencer.sv
// Autonomous AHB-Lite master: writes the GPIO direction register, then
// alternates two data patterns at a programmable period, reading back after each.
module ahb_gpio_sequencer #(
    parameter logic [31:0] GPIO_BASE = 32'h5300_0000,
    parameter int          PERIOD_W  = 16
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                start,
    input  logic                stop,
    input  logic [15:0]         dir_cfg,
    input  logic [15:0]         pattern_a,
    input  logic [15:0]         pattern_b,
    input  logic [7:0]          count,
    input  logic [PERIOD_W-1:0] period,
    ahb_gpio_sequencer_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [15:0]         last_in
);
    typedef enum logic [3:0] {
        S_IDLE, S_DIR_A, S_DIR_D, S_WAIT, S_WR_A, S_WR_D, S_RD_A, S_RD_D, S_DONE
    } state_t;

    localparam logic [1:0]          HT_IDLE    = 2'b00;
    localparam logic [1:0]          HT_NONSEQ  = 2'b10;
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [15:0]         dir_q, dir_d, pat_a_q, pat_a_d, pat_b_q, pat_b_d;
    logic [7:0]          count_q, count_d, wcnt_q, wcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d, wait_q, wait_d;
    logic                sel_q, sel_d;
    logic [31:0]         haddr_q, haddr_d, hwdata_q, hwdata_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                hwrite_q, hwrite_d;
    logic                busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic [15:0]         last_in_q, last_in_d;
    logic                unused_hrdata_s;

    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? PERIOD_ONE : p;
    endfunction

    // Next-state logic, then bus outputs derived from the state being entered
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pat_a_d   = pat_a_q;
        pat_b_d   = pat_b_q;
        count_d   = count_q;
        period_d  = period_q;
        wait_d    = wait_q;
        wcnt_d    = wcnt_q;
        sel_d     = sel_q;
        aborted_d = aborted_q;
        last_in_d = last_in_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hwdata_d  = hwdata_q;
        htrans_d  = HT_IDLE;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_DIR_A;
                    dir_d     = dir_cfg;
                    pat_a_d   = pattern_a;
                    pat_b_d   = pattern_b;
                    count_d   = count;
                    period_d  = period;
                    wcnt_d    = 8'd0;
                    sel_d     = 1'b0;
                    aborted_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIR_A: if (bus.HREADY) state_d = S_DIR_D; else state_d = S_DIR_A;
            S_DIR_D: begin
                if (bus.HREADY) begin
                    if (count_q == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        wait_d  = eff_period(period_q);
                    end
                end else begin
                    state_d = S_DIR_D;
                end
            end
            // stop is only honoured when the idle gap expires, never mid-transfer
            S_WAIT: begin
                if (wait_q <= PERIOD_ONE) begin
                    if (stop) begin
                        state_d   = S_DONE;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = S_WR_A;
                    end
                end else begin
                    wait_d = wait_q - PERIOD_ONE;
                end
            end
            S_WR_A: if (bus.HREADY) state_d = S_WR_D; else state_d = S_WR_A;
            S_WR_D: begin
                if (bus.HREADY) begin
                    state_d = S_RD_A;
                    sel_d   = ~sel_q;
                    wcnt_d  = wcnt_q + 8'd1;
                end else begin
                    state_d = S_WR_D;
                end
            end
            S_RD_A: if (bus.HREADY) state_d = S_RD_D; else state_d = S_RD_A;
            S_RD_D: begin
                if (bus.HREADY) begin
                    last_in_d = bus.HRDATA[15:0];
                    if (wcnt_q == count_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        wait_d  = eff_period(period_q);
                    end
                end else begin
                    state_d = S_RD_D;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Data-phase states leave HADDR/HWRITE untouched so they stay stable
        case (state_d)
            S_DIR_A: begin
                htrans_d = HT_NONSEQ;
                haddr_d  = GPIO_BASE + 32'd4;
                hwrite_d = 1'b1;
            end
            S_DIR_D: hwdata_d = {16'h0000, dir_q};
            S_WR_A: begin
                htrans_d = HT_NONSEQ;
                haddr_d  = GPIO_BASE;
                hwrite_d = 1'b1;
            end
            S_WR_D: hwdata_d = {16'h0000, (sel_q ? pat_b_q : pat_a_q)};
            S_RD_A: begin
                htrans_d = HT_NONSEQ;
                haddr_d  = GPIO_BASE;
                hwrite_d = 1'b0;
            end
            default: htrans_d = HT_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State, shadow and output registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            dir_q     <= 16'h0000;
            pat_a_q   <= 16'h0000;
            pat_b_q   <= 16'h0000;
            count_q   <= 8'd0;
            period_q  <= '0;
            wait_q    <= '0;
            wcnt_q    <= 8'd0;
            sel_q     <= 1'b0;
            haddr_q   <= 32'h0000_0000;
            htrans_q  <= HT_IDLE;
            hwrite_q  <= 1'b0;
            hwdata_q  <= 32'h0000_0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            last_in_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pat_a_q   <= pat_a_d;
            pat_b_q   <= pat_b_d;
            count_q   <= count_d;
            period_q  <= period_d;
            wait_q    <= wait_d;
            wcnt_q    <= wcnt_d;
            sel_q     <= sel_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            hwdata_q  <= hwdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            last_in_q <= last_in_d;
        end
    end

    assign bus.HADDR       = haddr_q;
    assign bus.HTRANS      = htrans_q;
    assign bus.HWRITE      = hwrite_q;
    assign bus.HSIZE       = 3'b010;
    assign bus.HWDATA      = hwdata_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign last_in         = last_in_q;
    assign unused_hrdata_s = ^bus.HRDATA[31:16];
endmodule

// File: tb/tb_ahb_gpio_sequencer.sv
// Scoreboard bench for ahb_gpio_sequencer: directed sequences queue expected bus
// transfers and done events; a negedge monitor pops and compares them.
module tb_ahb_gpio_sequencer;
    localparam logic [31:0] BASE = 32'h5300_0000;

    logic        HCLK = 1'b0, HRESETn = 1'b0, start = 1'b0, stop = 1'b0;
    logic [15:0] dir_cfg = 16'h0, pattern_a = 16'h0, pattern_b = 16'h0, period = 16'h0;
    logic [7:0]  count = 8'd0;
    logic [31:0] hrdata = 32'h0;
    logic        hready = 1'b1;
    logic        busy, done, aborted;
    logic [15:0] last_in;

    ahb_gpio_sequencer_if bus ();
    assign bus.HRDATA = hrdata;
    assign bus.HREADY = hready;

    ahb_gpio_sequencer #(.GPIO_BASE(BASE), .PERIOD_W(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .stop(stop),
        .dir_cfg(dir_cfg), .pattern_a(pattern_a), .pattern_b(pattern_b),
        .count(count), .period(period), .bus(bus),
        .busy(busy), .done(done), .aborted(aborted), .last_in(last_in)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;   // write/read data, or expected last_in for done
        int          offs;   // cycle offset from the start cycle
        bit          ab;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   vectors = 0, miscompares = 0, start_cyc = 0;
    bit   pend = 1'b0, pend_wr = 1'b0, lchk = 1'b0;
    logic [31:0] pend_addr = 32'h0, lexp = 32'h0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(string nm);
        vectors++;
        miscompares++;
        $display("FAIL unexpected_%s: got event at cycle %0d, expected none", nm, cyc);
    endtask

    task automatic push(bit d, bit wr, logic [31:0] a, logic [31:0] dt, int o, bit ab);
        exp_t e;
        e.is_done = d; e.wr = wr; e.addr = a; e.data = dt; e.offs = o; e.ab = ab;
        q.push_back(e);
    endtask

    // p is the effective period; stall is extra wait states inserted in the first WR_D
    task automatic plan(logic [15:0] dir, logic [15:0] a, logic [15:0] b, int n, int p,
                        int stall, logic [31:0] rd, logic [15:0] li0);
        push(1'b0, 1'b1, BASE + 32'd4, {16'h0, dir}, 2, 1'b0);
        for (int k = 0; k < n; k++) begin
            push(1'b0, 1'b1, BASE, {16'h0, ((k % 2) == 0) ? a : b}, 4 + p + k * (4 + p) + stall, 1'b0);
            push(1'b0, 1'b0, BASE, rd, 6 + p + k * (4 + p) + stall, 1'b0);
        end
        if (n > 0) push(1'b1, 1'b0, 32'h0, {16'h0, rd[15:0]}, 3 + n * (4 + p) + stall, 1'b0);
        else       push(1'b1, 1'b0, 32'h0, {16'h0, li0}, 3, 1'b0);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic kick(logic [15:0] d, logic [15:0] a, logic [15:0] b, logic [7:0] n, logic [15:0] p);
        step();
        dir_cfg = d; pattern_a = a; pattern_b = b; count = n; period = p;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic goto(int off);
        while (cyc < start_cyc + off) step();
    endtask

    task automatic drain(string nm);
        for (int i = 0; i < 400 && q.size() != 0; i++) step();
        chk({nm, "_pending_events"}, q.size(), 32'd0);
        step();
        step();
    endtask

    // Monitor: reconstruct AHB transfers and done pulses, compare with the queue
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            pend = 1'b0;
            lchk = 1'b0;
        end else begin
            if (lchk) begin
                chk("last_in_after_read", last_in, lexp);
                lchk = 1'b0;
            end
            if (done) begin
                if (q.size() == 0 || !q[0].is_done) unexpected("done");
                else begin
                    me = q.pop_front();
                    chk("done_offset", cyc - start_cyc, me.offs);
                    chk("done_aborted", aborted, me.ab);
                    chk("done_last_in", last_in, me.data);
                    chk("done_busy", busy, 32'd0);
                end
            end
            if (pend) begin
                if (bus.HREADY) begin
                    if (q.size() == 0 || q[0].is_done) unexpected("transfer");
                    else begin
                        me = q.pop_front();
                        chk("xfer_write", pend_wr, me.wr);
                        chk("xfer_addr", pend_addr, me.addr);
                        chk("xfer_data", pend_wr ? bus.HWDATA : bus.HRDATA, me.data);
                        chk("xfer_offset", cyc - start_cyc, me.offs);
                        chk("xfer_busy", busy, 32'd1);
                        if (!pend_wr) begin
                            lchk = 1'b1;
                            lexp = {16'h0, bus.HRDATA[15:0]};
                        end
                    end
                    pend = 1'b0;
                end else if (pend_wr && q.size() > 0 && !q[0].is_done) begin
                    chk("stall_haddr", bus.HADDR, q[0].addr);
                    chk("stall_hwdata", bus.HWDATA, q[0].data);
                end
            end
            if (bus.HTRANS == 2'b10 && bus.HREADY) begin
                pend      = 1'b1;
                pend_addr = bus.HADDR;
                pend_wr   = bus.HWRITE;
                chk("hsize", bus.HSIZE, 32'd2);
            end
        end
    end

    initial begin
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_htrans", bus.HTRANS, 32'h0);
        chk("rst_hwrite", bus.HWRITE, 32'h0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_done", done, 32'h0);
        chk("rst_aborted", aborted, 32'h0);
        chk("rst_last_in", last_in, 32'h0);
        HRESETn = 1'b1;

        // Direction write only
        plan(16'h0001, 16'h0, 16'h0, 0, 1, 0, 32'h0, 16'h0);
        kick(16'h0001, 16'h0, 16'h0, 8'd0, 16'd1);
        drain("t1");

        // Four alternating writes, period 2, read-back 0x1234
        hrdata = 32'h0000_1234;
        plan(16'hFFFF, 16'hAAAA, 16'h5555, 4, 2, 0, hrdata, 16'h0);
        kick(16'hFFFF, 16'hAAAA, 16'h5555, 8'd4, 16'd2);
        drain("t2");

        // Three wait states during WR_D
        hrdata = 32'hFFFF_BEEF;
        plan(16'h0F00, 16'hC3C3, 16'h3C3C, 1, 1, 3, hrdata, 16'h0);
        kick(16'h0F00, 16'hC3C3, 16'h3C3C, 8'd1, 16'd1);
        goto(5);
        hready = 1'b0;
        goto(8);
        hready = 1'b1;
        drain("t3");

        // Stop in the second WAIT; start pulses while busy are ignored
        hrdata = 32'h0000_0042;
        push(1'b0, 1'b1, BASE + 32'd4, 32'h0000_00FF, 2, 1'b0);
        push(1'b0, 1'b1, BASE, 32'h0000_1111, 7, 1'b0);
        push(1'b0, 1'b0, BASE, hrdata, 9, 1'b0);
        push(1'b1, 1'b0, 32'h0, 32'h0000_0042, 13, 1'b1);
        kick(16'h00FF, 16'h1111, 16'h2222, 8'd10, 16'd3);
        goto(5);
        start = 1'b1; count = 8'd1; pattern_a = 16'h7777;
        step();
        start = 1'b0;
        goto(10);
        stop = 1'b1;
        goto(11);
        start = 1'b1;
        step();
        start = 1'b0;
        drain("t4");
        stop = 1'b0;

        // Reset asserted in RD_A (period 0 behaves as 1)
        hrdata = 32'h0000_0099;
        push(1'b0, 1'b1, BASE + 32'd4, 32'h0000_0003, 2, 1'b0);
        push(1'b0, 1'b1, BASE, 32'h0000_8001, 5, 1'b0);
        kick(16'h0003, 16'h8001, 16'h8002, 8'd2, 16'd0);
        goto(6);
        HRESETn = 1'b0;
        #1;
        chk("arst_htrans", bus.HTRANS, 32'h0);
        chk("arst_busy", busy, 32'h0);
        chk("arst_done", done, 32'h0);
        chk("arst_haddr", bus.HADDR, 32'h0);
        chk("arst_last_in", last_in, 32'h0);
        chk("arst_pending_events", q.size(), 32'd0);
        step();
        step();
        HRESETn = 1'b1;

        // Full sequence after reset, period 0
        hrdata = 32'h0000_5A5A;
        plan(16'hA5A5, 16'h0F0F, 16'hF0F0, 3, 1, 0, hrdata, 16'h0);
        kick(16'hA5A5, 16'h0F0F, 16'hF0F0, 8'd3, 16'd0);
        drain("t5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ahb_gpio_sequencer.md
# ahb_gpio_sequencer

Autonomous AHB-Lite master that configures and drives the AHB GPIO peripheral without CPU involvement. It writes the GPIO direction register, then alternately writes two output patterns to the GPIO data register at a programmable period. After each pattern write it reads the data register back and exposes the sample. It sits on a dedicated master port of the bus segment that feeds the GPIO slave.

## Interface
Parameters:
- GPIO_BASE, 32'h5300_0000, byte base address of the GPIO slave; data register at +0x00, direction register at +0x04.
- PERIOD_W, 16, width of the inter-write period counter.

Ports:
- HCLK  input  1  system clock; all state changes on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sequence.
- stop  input  1  level request to end the sequence early.
- dir_cfg  input  16  value written to the direction register.
- pattern_a  input  16  first output pattern.
- pattern_b  input  16  second output pattern.
- count  input  8  number of pattern writes; 0 means direction write only.
- period  input  PERIOD_W  idle cycles before each pattern write; 0 is treated as 1.
- HADDR  output  32  AHB address.
- HTRANS  output  2  AHB transfer type; only IDLE (2'b00) and NONSEQ (2'b10) are used.
- HWRITE  output  1  AHB write strobe.
- HSIZE  output  3  fixed 3'b010 (word).
- HWDATA  output  32  write data; upper 16 bits are zero.
- HRDATA  input  32  read data; bits [15:0] are used.
- HREADY  input  1  transfer-complete / address-accept from the bus.
- busy  output  1  high from the cycle after an accepted start until the return to IDLE.
- done  output  1  one-cycle pulse when a sequence ends.
- aborted  output  1  set with done if the sequence ended via stop; cleared on the next accepted start.
- last_in  output  16  most recent GPIO data register read-back.

## Operation
- Reset values: HADDR=0, HTRANS=IDLE, HWRITE=0, HWDATA=0, busy=0, done=0, aborted=0, last_in=0, FSM in IDLE.
- start is accepted only in IDLE. Acceptance latches dir_cfg, pattern_a, pattern_b, count and period into shadow registers, and clears the write counter and the pattern selector (selector = A). start outside IDLE is ignored.
- FSM states: IDLE, DIR_A, DIR_D, WAIT, WR_A, WR_D, RD_A, RD_D, DONE.
- IDLE -> DIR_A on accepted start.
- DIR_A drives HTRANS=NONSEQ, HADDR=GPIO_BASE+4, HWRITE=1. Goes to DIR_D when HREADY=1.
- DIR_D drives HTRANS=IDLE and HWDATA={16'h0, dir_cfg}. When HREADY=1: goes to DONE if count=0, otherwise to WAIT with the period counter loaded.
- WAIT holds the bus IDLE and decrements the counter. It exits after max(period,1) cycles:
  - to DONE if stop=1 when the counter expires, with aborted=1;
  - otherwise to WR_A.
- WR_A drives NONSEQ to GPIO_BASE+0 with HWRITE=1. Goes to WR_D when HREADY=1.
- WR_D drives HWDATA with the selected pattern. When HREADY=1: toggles the selector, increments the write counter, goes to RD_A.
- RD_A drives NONSEQ to GPIO_BASE+0 with HWRITE=0. Goes to RD_D when HREADY=1.
- RD_D: when HREADY=1, captures last_in<=HRDATA[15:0]. Goes to DONE if the write counter equals count, otherwise to WAIT with the period counter reloaded.
- DONE pulses done for one cycle and goes to IDLE.
- Transfers are never pipelined: HTRANS is IDLE in every data-phase state.
- stop never aborts a transfer in flight; it is checked only at the end of WAIT.
- Address, control and data stay stable while HREADY=0 (wait states).
- The write counter is 8-bit; count=255 gives 255 writes with no wrap.

## Timing
- Zero-wait-state bus (HREADY=1 throughout), start sampled high at edge 0:
  - busy and the DIR_A address phase appear after edge 0;
  - DIR_D follows after edge 1;
  - WAIT begins after edge 2;
  - the first WR_A appears after edge 2+max(period,1).
- Each pattern iteration occupies 4 bus cycles plus max(period,1) WAIT cycles.
- last_in updates on the edge that completes RD_D.
- done is high in the single cycle after the final RD_D (or DIR_D, or aborting WAIT) completes. busy falls in the same cycle that done is high.
- Each extra HREADY=0 cycle stretches the affected state by exactly one cycle.
- An asynchronous reset at any point forces all outputs to their reset values immediately. No done pulse is issued.

## Test plan
- dir_cfg=16'h0001, count=0, HREADY=1: exactly one write of 0x0000_0001 to 0x5300_0004. done occurs 3 cycles after start; aborted=0.
- count=4, period=2, pattern_a=16'hAAAA, pattern_b=16'h5555: the data register receives AAAA, 5555, AAAA, 5555. Consecutive WR_A phases are 6 cycles apart. Four reads occur and then done.
- HRDATA=32'h0000_1234 during every RD_D: last_in=16'h1234 after the first read completes.
- HREADY held low for 3 cycles during WR_D: HADDR and HWDATA stay stable; the whole sequence is delayed by exactly 3 cycles.
- stop asserted during the second WAIT with count=10: exactly 1 pattern write occurs, then done with aborted=1; start pulses while busy have no effect.
- HRESETn asserted in RD_A: HTRANS=IDLE and busy=0 immediately. After release a new start runs a full sequence normally.
